// File: rtl/rice_bus_arbiter_pkg.sv
//==============================================================================
// Module : rice_bus_arbiter_pkg
// Brief  : Shared widths, index-width helper and request struct for the arbiter.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rice_bus_arbiter_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 64;
  localparam int DEFAULT_DATA_WIDTH    = 64;
  localparam int DEFAULT_STROBE_WIDTH  = DEFAULT_DATA_WIDTH / 8;

  // A single master still needs a one-bit index so the ID FIFO has a width.
  function automatic int index_width(input int masters);
    return (masters > 1) ? $clog2(masters) : 1;
  endfunction

  typedef struct packed {
    logic [DEFAULT_ADDRESS_WIDTH-1:0] address;
    logic [DEFAULT_STROBE_WIDTH-1:0]  strobe;
    logic [DEFAULT_DATA_WIDTH-1:0]    write_data;
  } request_t;

endpackage

`default_nettype wire

// File: rtl/rice_bus_arbiter_id_fifo.sv
//==============================================================================
// Module : rice_bus_arbiter_id_fifo
// Brief  : In-order FIFO of grant indices for accepted, unanswered requests.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rice_bus_arbiter_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // Explicit wrap keeps non-power-of-two-safe behaviour and a depth of one.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rice_bus_arbiter.sv
//==============================================================================
// Module : rice_bus_arbiter
// Brief  : Shares one rice bus slave between masters; routes responses in order.
//          RICE_BUS_ARBITER_ROUND_ROBIN_EN selects round-robin over fixed priority.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rice_bus_arbiter
  import rice_bus_arbiter_pkg::*;
#(
  parameter int  MASTERS         = 2,
  parameter int  MAX_OUTSTANDING = 4,
  parameter int  ADDRESS_WIDTH   = DEFAULT_ADDRESS_WIDTH,
  parameter int  DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  localparam int STROBE_WIDTH    = DATA_WIDTH / 8,
  localparam int IW              = index_width(MASTERS)
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [MASTERS-1:0]                i_m_request_valid,
  output logic [MASTERS-1:0]                o_m_request_ready,
  input  logic [MASTERS*ADDRESS_WIDTH-1:0]  i_m_address,
  input  logic [MASTERS*STROBE_WIDTH-1:0]   i_m_strobe,
  input  logic [MASTERS*DATA_WIDTH-1:0]     i_m_write_data,
  output logic [MASTERS-1:0]                o_m_response_valid,
  input  logic [MASTERS-1:0]                i_m_response_ready,
  output logic [DATA_WIDTH-1:0]             o_m_read_data,
  output logic                              o_s_request_valid,
  input  logic                              i_s_request_ready,
  output logic [ADDRESS_WIDTH-1:0]          o_s_address,
  output logic [STROBE_WIDTH-1:0]           o_s_strobe,
  output logic [DATA_WIDTH-1:0]             o_s_write_data,
  input  logic                              i_s_response_valid,
  output logic                              o_s_response_ready,
  input  logic [DATA_WIDTH-1:0]             i_s_read_data
);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] address;
    logic [STROBE_WIDTH-1:0]  strobe;
    logic [DATA_WIDTH-1:0]    write_data;
  } slave_request_t;

  slave_request_t requests [MASTERS];
  logic           lock;
  logic [IW-1:0]  locked_idx;
  logic [IW-1:0]  sel;
  logic [IW-1:0]  grant;
  logic [IW-1:0]  head;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

  for (genvar m = 0; m < MASTERS; m++) begin : g_unpack
    assign requests[m].address    = i_m_address[m*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign requests[m].strobe     = i_m_strobe[m*STROBE_WIDTH +: STROBE_WIDTH];
    assign requests[m].write_data = i_m_write_data[m*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef RICE_BUS_ARBITER_ROUND_ROBIN_EN
  logic [IW-1:0] last_grant;

  always_comb begin
    logic found;
    int   idx;
    sel   = last_grant;
    found = 1'b0;
    for (int k = 1; k <= MASTERS; k++) begin
      idx = (int'(last_grant) + k) % MASTERS;
      if (!found && i_m_request_valid[idx]) begin
        sel   = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant <= IW'(MASTERS - 1);
    end else if (push) begin
      last_grant <= grant;
    end
  end
`else
  always_comb begin
    sel = '0;
    for (int i = MASTERS - 1; i >= 0; i--) begin
      if (i_m_request_valid[i]) begin
        sel = IW'(i);
      end
    end
  end
`endif

  // A request waiting on the slave pins the grant until it is accepted.
  assign grant             = lock ? locked_idx : sel;
  assign o_s_request_valid = i_m_request_valid[grant] && !full;
  assign push              = o_s_request_valid && i_s_request_ready;
  assign {o_s_address, o_s_strobe, o_s_write_data} = requests[grant];

  always_comb begin
    o_m_request_ready        = '0;
    o_m_request_ready[grant] = o_s_request_valid && i_s_request_ready;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock       <= 1'b0;
      locked_idx <= '0;
    end else if (push) begin
      lock       <= 1'b0;
    end else if (!lock && o_s_request_valid) begin
      lock       <= 1'b1;
      locked_idx <= grant;
    end
  end

  assign o_s_response_ready = !empty && i_m_response_ready[head];
  assign pop                = i_s_response_valid && o_s_response_ready;
  assign o_m_read_data      = i_s_read_data;

  always_comb begin
    o_m_response_valid       = '0;
    o_m_response_valid[head] = i_s_response_valid && !empty;
  end

  rice_bus_arbiter_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) u_id_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data (grant),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

endmodule

`default_nettype wire

// File: tb/tb_rice_bus_arbiter.sv
//==============================================================================
// Module : tb_rice_bus_arbiter
// Brief  : Directed self-checking bench for rice_bus_arbiter (2 masters, depth 4).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rice_bus_arbiter;

  logic         clk;
  logic         rst_n;
  logic [1:0]   m_req_valid;
  logic [1:0]   m_req_ready;
  logic [127:0] m_addr;
  logic [15:0]  m_strb;
  logic [127:0] m_wdata;
  logic [1:0]   m_resp_valid;
  logic [1:0]   m_resp_ready;
  logic [63:0]  m_rdata;
  logic         s_req_valid;
  logic         s_req_ready;
  logic [63:0]  s_addr;
  logic [7:0]   s_strb;
  logic [63:0]  s_wdata;
  logic         s_resp_valid;
  logic         s_resp_ready;
  logic [63:0]  s_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] t5_seq [4];

  rice_bus_arbiter #(
    .MASTERS         (2),
    .MAX_OUTSTANDING (4),
    .ADDRESS_WIDTH   (64),
    .DATA_WIDTH      (64)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_m_request_valid  (m_req_valid),
    .o_m_request_ready  (m_req_ready),
    .i_m_address        (m_addr),
    .i_m_strobe         (m_strb),
    .i_m_write_data     (m_wdata),
    .o_m_response_valid (m_resp_valid),
    .i_m_response_ready (m_resp_ready),
    .o_m_read_data      (m_rdata),
    .o_s_request_valid  (s_req_valid),
    .i_s_request_ready  (s_req_ready),
    .o_s_address        (s_addr),
    .o_s_strobe         (s_strb),
    .o_s_write_data     (s_wdata),
    .i_s_response_valid (s_resp_valid),
    .o_s_response_ready (s_resp_ready),
    .i_s_read_data      (s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; m_req_valid = '0; m_addr = '0; m_strb = '0; m_wdata = '0;
    m_resp_ready = '0; s_req_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = '0;
    t5_seq[0] = 2'b01; t5_seq[1] = 2'b10; t5_seq[2] = 2'b10; t5_seq[3] = 2'b01;
    #1;
    chk("rst_s_req_valid", 64'(s_req_valid), 64'd0);
    chk("rst_m_req_ready", 64'(m_req_ready), 64'd0);
    chk("rst_m_resp_valid", 64'(m_resp_valid), 64'd0);
    chk("rst_s_resp_ready", 64'(s_resp_ready), 64'd0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;

    // Single read from master 1
    m_addr[64 +: 64] = 64'h1000; m_req_valid = 2'b10; s_req_ready = 1'b1; #1;
    chk("t1_addr", s_addr, 64'h1000);
    chk("t1_s_req_valid", 64'(s_req_valid), 64'd1);
    chk("t1_m_req_ready", 64'(m_req_ready), 64'b10);
    tick;
    m_req_valid = '0; s_resp_valid = 1'b1; s_rdata = 64'hDEAD_BEEF; m_resp_ready = 2'b11; #1;
    chk("t1_resp_valid", 64'(m_resp_valid), 64'b10);
    chk("t1_rdata", m_rdata, 64'hDEAD_BEEF);
    chk("t1_s_resp_ready", 64'(s_resp_ready), 64'd1);
    tick; #1;
    chk("empty_resp_valid", 64'(m_resp_valid), 64'd0);
    chk("empty_s_resp_ready", 64'(s_resp_ready), 64'd0);
    s_resp_valid = 1'b0;

    // Simultaneous requests
    m_addr[0 +: 64] = 64'h2000; m_strb[7:0] = 8'hFF; m_wdata[63:0] = 64'h1111_2222_3333_4444;
    m_addr[64 +: 64] = 64'h3000; m_req_valid = 2'b11; #1;
    chk("t2_g0_ready", 64'(m_req_ready), 64'b01);
    chk("t2_g0_addr", s_addr, 64'h2000);
    chk("t2_g0_strb", 64'(s_strb), 64'hFF);
    chk("t2_g0_wdata", s_wdata, 64'h1111_2222_3333_4444);
    tick;
`ifndef RICE_BUS_ARBITER_ROUND_ROBIN_EN
    m_req_valid = 2'b10;
`endif
    #1;
    chk("t2_g1_ready", 64'(m_req_ready), 64'b10);
    chk("t2_g1_addr", s_addr, 64'h3000);
    chk("t2_g1_strb", 64'(s_strb), 64'h00);
    tick;
    m_req_valid = '0; s_resp_valid = 1'b1; #1;
    chk("t2_resp0", 64'(m_resp_valid), 64'b01);
    tick; #1;
    chk("t2_resp1", 64'(m_resp_valid), 64'b10);
    tick;
    s_resp_valid = 1'b0;

    // Lock holds master 1 while the slave stalls
    s_req_ready = 1'b0; m_req_valid = 2'b10; #1;
    chk("t3_stall_valid", 64'(s_req_valid), 64'd1);
    chk("t3_stall_ready", 64'(m_req_ready), 64'd0);
    tick; tick; tick;
    m_req_valid = 2'b11; #1;
    chk("t3_hold_addr", s_addr, 64'h3000);
    s_req_ready = 1'b1; #1;
    chk("t3_hold_ready", 64'(m_req_ready), 64'b10);
    tick;
    m_req_valid = 2'b01; #1;
    chk("t3_next_ready", 64'(m_req_ready), 64'b01);
    chk("t3_next_addr", s_addr, 64'h2000);
    tick;
    m_req_valid = '0; s_resp_valid = 1'b1; #1;
    chk("t3_resp1", 64'(m_resp_valid), 64'b10);
    tick; #1;
    chk("t3_resp0", 64'(m_resp_valid), 64'b01);
    tick;
    s_resp_valid = 1'b0;

    // Fill to MAX_OUTSTANDING
    m_req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_issue_ready", 64'(m_req_ready), 64'b01);
      tick;
    end
    #1;
    chk("t4_full_valid", 64'(s_req_valid), 64'd0);
    chk("t4_full_ready", 64'(m_req_ready), 64'd0);
    s_resp_valid = 1'b1; #1;
    chk("t4_pop_same_cycle_ready", 64'(m_req_ready), 64'd0);
    chk("t4_pop_resp_valid", 64'(m_resp_valid), 64'b01);
    tick;
    s_resp_valid = 1'b0; #1;
    chk("t4_resume_ready", 64'(m_req_ready), 64'b01);
    tick;
    m_req_valid = '0; s_resp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_drain_valid", 64'(m_resp_valid), 64'b01);
      tick;
    end
    #1;
    chk("t4_drained", 64'(m_resp_valid), 64'd0);
    s_resp_valid = 1'b0;

    // Interleaved issue 0,1,1,0 and in-order routing
    for (int i = 0; i < 4; i++) begin
      m_req_valid = t5_seq[i]; #1;
      chk("t5_issue_ready", 64'(m_req_ready), 64'(t5_seq[i]));
      tick;
    end
    m_req_valid = '0;
    s_resp_valid = 1'b1; s_rdata = 64'hA; #1;
    chk("t5_resp_a_valid", 64'(m_resp_valid), 64'b01);
    chk("t5_resp_a_data", m_rdata, 64'hA);
    tick;
    s_rdata = 64'hB; m_resp_ready = 2'b01; #1;
    chk("t5_resp_b_valid", 64'(m_resp_valid), 64'b10);
    chk("t5_stall_s_resp_ready", 64'(s_resp_ready), 64'd0);
    tick; #1;
    chk("t5_resp_b_held", 64'(m_resp_valid), 64'b10);
    m_resp_ready = 2'b11; #1;
    chk("t5_resp_b_ready", 64'(s_resp_ready), 64'd1);
    chk("t5_resp_b_data", m_rdata, 64'hB);
    tick;
    s_rdata = 64'hC; #1;
    chk("t5_resp_c_valid", 64'(m_resp_valid), 64'b10);
    tick;
    s_rdata = 64'hD; #1;
    chk("t5_resp_d_valid", 64'(m_resp_valid), 64'b01);
    tick;
    s_resp_valid = 1'b0;

    // Reset with two outstanding
    m_req_valid = 2'b01;
    tick; tick;
    m_req_valid = '0; s_resp_valid = 1'b1; #1;
    chk("t6_pre_rst_resp", 64'(m_resp_valid), 64'b01);
    rst_n = 1'b0; #1;
    chk("t6_rst_resp_valid", 64'(m_resp_valid), 64'd0);
    chk("t6_rst_s_resp_ready", 64'(s_resp_ready), 64'd0);
    chk("t6_rst_s_req_valid", 64'(s_req_valid), 64'd0);
    tick;
    rst_n = 1'b1; #1;
    chk("t6_post_rst_empty", 64'(m_resp_valid), 64'd0);
    s_resp_valid = 1'b0; m_req_valid = 2'b01; #1;
    chk("t6_post_rst_ready", 64'(m_req_ready), 64'b01);
    tick;
    m_req_valid = '0; s_resp_valid = 1'b1; #1;
    chk("t6_post_rst_resp", 64'(m_resp_valid), 64'b01);
    tick; #1;
    chk("t6_post_rst_drained", 64'(m_resp_valid), 64'd0);
    s_resp_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
